// File: rtl/twp_pkg.sv
// Shared types and constants for the TWP master controller.
package twp_pkg;

  localparam int TWP_ADDR_BITS = 8;
  localparam int TWP_DATA_BITS = 16;

  localparam logic TWP_CMD_WRITE = 1'b1;

  localparam int TWP_TIMEOUT_DEF  = 64;
  localparam int TWP_IDLE_GAP_DEF = 2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_TURN,
    ST_RDATA,
    ST_TAIL,
    ST_GAP,
    ST_DONE
  } twp_state_e;

endpackage

// File: rtl/twp_shifter.sv
// LSB-first shift register: parallel load, serial out from bit 0, serial in at the MSB.
module twp_shifter
  import twp_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     load,
  input  logic                     shift,
  input  logic                     sin,
  input  logic [TWP_DATA_BITS-1:0] din,
  output logic                     sout,
  output logic [TWP_DATA_BITS-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {sin, q[TWP_DATA_BITS-1:1]};
    end
  end

  assign sout = q[0];

endmodule

// File: rtl/twp_master_ctrl.sv
// TWP master: serializes one host read/write command onto SCL/SDA and returns
// the read data or an error on a single-cycle response pulse.
//
//   state | meaning
//   IDLE  | bus high, waiting for a host command
//   START | start bit (0)
//   CMD   | write/read flag
//   ADDR  | 8 address bits, LSB first
//   WDATA | 16 write data bits, LSB first
//   TURN  | SDA released, waiting for the slave's 0 start bit
//   RDATA | 16 read data bits captured, LSB first
//   TAIL  | slave tail bit, must be 1
//   GAP   | bus held high before completion
//   DONE  | response pulse
module twp_master_ctrl
  import twp_pkg::*;
#(
  parameter int TIMEOUT  = TWP_TIMEOUT_DEF,
  parameter int IDLE_GAP = TWP_IDLE_GAP_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [TWP_ADDR_BITS-1:0] cmd_addr,
  input  logic [TWP_DATA_BITS-1:0] cmd_wdata,
  output logic                     rsp_valid,
  output logic [TWP_DATA_BITS-1:0] rsp_rdata,
  output logic                     rsp_err,
  output logic                     busy,
  output logic                     SCL,
  inout  wire                      SDA
);

  localparam int              TO_W     = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LOAD  = TO_W'(TIMEOUT);
  localparam logic [3:0]      GAP_LAST = 4'(IDLE_GAP - 1);
  localparam logic [3:0]      ADDR_LAST = 4'(TWP_ADDR_BITS - 1);
  localparam logic [3:0]      DATA_LAST = 4'(TWP_DATA_BITS - 1);

  twp_state_e               state;
  logic [3:0]               bit_cnt;
  logic [TO_W-1:0]          to_cnt;
  logic                     wr_q;
  logic [TWP_ADDR_BITS-1:0] addr_sh;
  logic                     err_q;
  logic                     sda_oe;
  logic                     sda_o;
  logic                     sda_in;
  logic                     accept;
  logic                     turn_start;
  logic                     turn_expire;

  logic                     sh_load;
  logic                     sh_shift;
  logic [TWP_DATA_BITS-1:0] sh_din;
  logic                     sh_sout;
  logic [TWP_DATA_BITS-1:0] sh_q;

  assign sda_in = SDA;
  assign SDA    = sda_oe ? sda_o : 1'bz;
  assign SCL    = busy;
  assign accept = cmd_valid & cmd_ready;

  assign turn_start  = (state == ST_TURN) && (sda_in == 1'b0);
  assign turn_expire = (state == ST_TURN) && !turn_start && (to_cnt == '0);

  // One shifter serves both directions: write data is loaded on accept and
  // shifted out; read data is shifted in. A timeout reloads it with zero.
  always_comb begin
    sh_load  = accept | turn_expire;
    sh_din   = accept ? cmd_wdata : '0;
    sh_shift = 1'b0;
    case (state)
      ST_ADDR:  sh_shift = (bit_cnt == ADDR_LAST) && (wr_q == TWP_CMD_WRITE);
      ST_WDATA: sh_shift = 1'b1;
      ST_RDATA: sh_shift = 1'b1;
      default:  sh_shift = 1'b0;
    endcase
  end

  twp_shifter u_shifter (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (sh_load),
    .shift   (sh_shift),
    .sin     (sda_in),
    .din     (sh_din),
    .sout    (sh_sout),
    .q       (sh_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      to_cnt    <= '0;
      wr_q      <= 1'b0;
      addr_sh   <= '0;
      err_q     <= 1'b0;
      sda_oe    <= 1'b1;
      sda_o     <= 1'b1;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          sda_oe <= 1'b1;
          sda_o  <= 1'b1;
          if (accept) begin
            wr_q      <= cmd_write;
            addr_sh   <= cmd_addr;
            err_q     <= 1'b0;
            state     <= ST_START;
            bit_cnt   <= '0;
            sda_o     <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end

        ST_START: begin
          state   <= ST_CMD;
          bit_cnt <= '0;
          sda_o   <= wr_q;
        end

        ST_CMD: begin
          state   <= ST_ADDR;
          bit_cnt <= '0;
          sda_o   <= addr_sh[0];
          addr_sh <= addr_sh >> 1;
        end

        ST_ADDR: begin
          if (bit_cnt == ADDR_LAST) begin
            bit_cnt <= '0;
            if (wr_q == TWP_CMD_WRITE) begin
              state <= ST_WDATA;
              sda_o <= sh_sout;
            end else begin
              state  <= ST_TURN;
              sda_oe <= 1'b0;
              to_cnt <= TO_LOAD;
            end
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
            sda_o   <= addr_sh[0];
            addr_sh <= addr_sh >> 1;
          end
        end

        ST_WDATA: begin
          if (bit_cnt == DATA_LAST) begin
            state   <= ST_GAP;
            bit_cnt <= '0;
            sda_o   <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
            sda_o   <= sh_sout;
          end
        end

        // Down-counter gives TIMEOUT+1 cycles of waiting before giving up.
        ST_TURN: begin
          if (turn_start) begin
            state   <= ST_RDATA;
            bit_cnt <= '0;
            to_cnt  <= '0;
          end else if (turn_expire) begin
            state   <= ST_GAP;
            bit_cnt <= '0;
            err_q   <= 1'b1;
            sda_oe  <= 1'b1;
            sda_o   <= 1'b1;
          end else begin
            to_cnt <= to_cnt - TO_W'(1);
          end
        end

        ST_RDATA: begin
          if (bit_cnt == DATA_LAST) begin
            state   <= ST_TAIL;
            bit_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end

        ST_TAIL: begin
          state   <= ST_GAP;
          bit_cnt <= '0;
          sda_oe  <= 1'b1;
          sda_o   <= 1'b1;
          if (sda_in != 1'b1) begin
            err_q <= 1'b1;
          end
        end

        ST_GAP: begin
          sda_oe <= 1'b1;
          sda_o  <= 1'b1;
          if (bit_cnt == GAP_LAST) begin
            state     <= ST_DONE;
            bit_cnt   <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= err_q;
            rsp_rdata <= (wr_q == TWP_CMD_WRITE) ? '0 : sh_q;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end

        ST_DONE: begin
          state     <= ST_IDLE;
          bit_cnt   <= '0;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end

        default: begin
          state     <= ST_IDLE;
          bit_cnt   <= '0;
          to_cnt    <= '0;
          sda_oe    <= 1'b1;
          sda_o     <= 1'b1;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
